// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the inst->dec->exe->wb pipeline.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise every RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int MC_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [REG_AW-1:0]   dec_rs1,
  input  logic                dec_rs1_use,
  input  logic [REG_AW-1:0]   dec_rs2,
  input  logic                dec_rs2_use,
  input  logic [REG_AW-1:0]   dec_rd,
  input  logic                dec_rd_we,
  input  logic                dec_is_load,
  input  logic [MC_CNT_W-1:0] dec_mc_len,
  input  logic                br_taken,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic                flush_if,
  output logic                flush_id,
  output logic                exe_busy,
  output logic [1:0]          fwd_rs1_sel,
  output logic [1:0]          fwd_rs2_sel
);

  logic [REG_AW-1:0]   exRd_q, exRd_d, wbRd_q, wbRd_d;
  logic                exWe_q, exWe_d, wbWe_q, wbWe_d;
  logic [MC_CNT_W-1:0] mcCnt_q, mcCnt_d;
  logic                firstCyc_q;
  logic                busy, rawHaz;
  logic                mEx1, mWb1, mEx2, mWb2;
  logic [1:0]          fwd1, fwd2;

  assign busy = (mcCnt_q != '0);
  assign mEx1 = dec_rs1_use & exWe_q & (dec_rs1 == exRd_q) & (dec_rs1 != '0);
  assign mWb1 = dec_rs1_use & wbWe_q & (dec_rs1 == wbRd_q) & (dec_rs1 != '0);
  assign mEx2 = dec_rs2_use & exWe_q & (dec_rs2 == exRd_q) & (dec_rs2 != '0);
  assign mWb2 = dec_rs2_use & wbWe_q & (dec_rs2 == wbRd_q) & (dec_rs2 != '0);

`ifdef PIPE_FWD_EN
  logic exLoad_q, exLoad_d;

  // Only a load still in exe cannot be forwarded; its data arrives one cycle later.
  assign rawHaz = dec_valid & exLoad_q & (mEx1 | mEx2);
  assign fwd1   = !dec_valid ? 2'd0 : (mEx1 & !exLoad_q) ? 2'd1 : mWb1 ? 2'd2 : 2'd0;
  assign fwd2   = !dec_valid ? 2'd0 : (mEx2 & !exLoad_q) ? 2'd1 : mWb2 ? 2'd2 : 2'd0;

  always_comb begin
    exLoad_d = exLoad_q;
    if (!busy) exLoad_d = dec_valid & !bubble_ex & dec_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exLoad_q <= 1'b0;
    else     exLoad_q <= exLoad_d;
  end
`else
  logic unusedIsLoad;

  assign unusedIsLoad = dec_is_load;
  assign rawHaz = dec_valid & (mEx1 | mWb1 | mEx2 | mWb2);
  assign fwd1   = 2'd0;
  assign fwd2   = 2'd0;
`endif

  // Outputs are forced quiet during reset and the first cycle after it.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    exe_busy    = 1'b0;
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    if (!firstCyc_q) begin
      if (busy) begin
        exe_busy = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (br_taken) begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (rawHaz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      fwd_rs1_sel = fwd1;
      fwd_rs2_sel = fwd2;
    end
  end

  // While a multi-cycle op runs, exe holds it and wb receives empty slots.
  always_comb begin
    exRd_d  = exRd_q;
    exWe_d  = exWe_q;
    wbRd_d  = wbRd_q;
    wbWe_d  = wbWe_q;
    mcCnt_d = mcCnt_q;
    if (busy) begin
      wbRd_d  = '0;
      wbWe_d  = 1'b0;
      mcCnt_d = mcCnt_q - MC_CNT_W'(1);
    end else begin
      wbRd_d = exRd_q;
      wbWe_d = exWe_q;
      if (dec_valid && !bubble_ex) begin
        exRd_d  = dec_rd;
        exWe_d  = dec_rd_we;
        mcCnt_d = dec_mc_len;
      end else begin
        exRd_d  = '0;
        exWe_d  = 1'b0;
        mcCnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exRd_q     <= '0;
      exWe_q     <= 1'b0;
      wbRd_q     <= '0;
      wbWe_q     <= 1'b0;
      mcCnt_q    <= '0;
      firstCyc_q <= 1'b1;
    end else begin
      exRd_q     <= exRd_d;
      exWe_q     <= exWe_d;
      wbRd_q     <= wbRd_d;
      wbWe_q     <= wbWe_d;
      mcCnt_q    <= mcCnt_d;
      firstCyc_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences and a
// randomized run against a queue-based pipeline model (honours PIPE_FWD_EN).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_rs1_use, dec_rs2_use, dec_rd_we, dec_is_load, br_taken;
  logic [3:0] dec_rs1, dec_rs2, dec_rd, dec_mc_len;
  logic       stall_if, stall_id, bubble_ex, flush_if, flush_id, exe_busy;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

  int vecCount  = 0;
  int missCount = 0;

  // Output vector layout: {stall_if,stall_id,bubble_ex,flush_if,flush_id,exe_busy,fwd1[1:0],fwd2[1:0]}
  localparam logic [9:0] QUIET = 10'h000;
  localparam logic [9:0] STALL = 10'h380;
  localparam logic [9:0] BUSY  = 10'h310;
  localparam logic [9:0] FLUSH = 10'h0E0;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_hazard_ctrl #(.REG_AW(4), .MC_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs1_use(dec_rs1_use),
    .dec_rs2(dec_rs2), .dec_rs2_use(dec_rs2_use), .dec_rd(dec_rd),
    .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load), .dec_mc_len(dec_mc_len),
    .br_taken(br_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .exe_busy(exe_busy),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dutOut();
    return {stall_if, stall_id, bubble_ex, flush_if, flush_id, exe_busy, fwd_rs1_sel, fwd_rs2_sel};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic u1,
                               input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                               input logic we, input logic ld, input logic [3:0] mc,
                               input logic br);
    dec_valid   = v;
    dec_rs1     = rs1;
    dec_rs1_use = u1;
    dec_rs2     = rs2;
    dec_rs2_use = u2;
    dec_rd      = rd;
    dec_rd_we   = we;
    dec_is_load = ld;
    dec_mc_len  = mc;
    br_taken    = br;
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // br_taken is held high through reset to show the output gating.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("reset_hold", int'(dutOut()), int'(QUIET));
    step();
    rst = 1'b0;
    #2;
    checkOutput("reset_first_cycle", int'(dutOut()), int'(QUIET));
    step();
    idle();
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] rd;
    logic       we;
    logic       load;
  } slot_t;

  slot_t flight[$];
  int    mcLeft;

  function automatic bit hit(input logic [3:0] src, input logic use_, input slot_t s);
    return use_ && s.we && (src == s.rd) && (src != 4'd0);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [3:0] src, input logic use_);
    if (!FWD || !dec_valid) return 2'd0;
    if (hit(src, use_, flight[0]) && !flight[0].load) return 2'd1;
    if (hit(src, use_, flight[1])) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [9:0] modelOut();
    logic [9:0] o;
    bit exHit, wbHit, haz;
    exHit = hit(dec_rs1, dec_rs1_use, flight[0]) || hit(dec_rs2, dec_rs2_use, flight[0]);
    wbHit = hit(dec_rs1, dec_rs1_use, flight[1]) || hit(dec_rs2, dec_rs2_use, flight[1]);
    haz   = FWD ? (dec_valid && exHit && flight[0].load) : (dec_valid && (exHit || wbHit));
    if (mcLeft > 0)    o = BUSY;
    else if (br_taken) o = FLUSH;
    else if (haz)      o = STALL;
    else               o = QUIET;
    o[3:2] = fwdSel(dec_rs1, dec_rs1_use);
    o[1:0] = fwdSel(dec_rs2, dec_rs2_use);
    return o;
  endfunction

  task automatic modelAdvance(input logic bub);
    slot_t s;
    if (mcLeft > 0) begin
      flight[1] = '0;
      mcLeft--;
    end else begin
      void'(flight.pop_back());
      s = '0;
      if (dec_valid && !bub) begin
        s.rd   = dec_rd;
        s.we   = dec_rd_we;
        s.load = dec_is_load;
        mcLeft = int'(dec_mc_len);
      end
      flight.push_front(s);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] pRd;
    logic       pWe;
    logic       pLoad;
    int         gap;
    logic [3:0] cRs1;
    logic       cU1;
    logic [3:0] cRs2;
    logic       cU2;
    logic [9:0] expNo;
    logic [9:0] expFw;
  } vec_t;

  vec_t vecs[10];

  task automatic runRaw(input string name, input logic ld, input logic [3:0] reg_,
                        input int expBub, input logic [1:0] expFwd);
    int bubbles;
    doReset();
    applyStimulus(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, reg_, 1'b1, ld, 4'd0, 1'b0);
    step();
    bubbles = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, reg_, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
      if (!stall_id) break;
      if (bubble_ex) bubbles++;
      step();
    end
    checkOutput({name, "_bubbles"}, bubbles, expBub);
    checkOutput({name, "_fwd1"}, int'(fwd_rs1_sel), int'(expFwd));
  endtask

  task automatic runMc(input logic [3:0] n);
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, n, 1'b0);
    checkOutput("mc_issue", int'(dutOut()), int'(QUIET));
    step();
    for (int c = 0; c < int'(n); c++) begin
      applyStimulus(1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("mc%0d_busy_c%0d", n, c), int'(dutOut()), int'(BUSY));
      step();
    end
    applyStimulus(1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput($sformatf("mc%0d_done", n), int'(dutOut()), int'(QUIET));
  endtask

  initial begin
    logic [9:0] exp;
    logic [3:0] mc;
    int         r;

    rst = 1'b0;
    idle();

    vecs[0] = '{4'd3, 1'b1, 1'b0, 0, 4'd3, 1'b1, 4'd0, 1'b0, STALL, 10'h004};
    vecs[1] = '{4'd3, 1'b1, 1'b0, 1, 4'd3, 1'b1, 4'd0, 1'b0, STALL, 10'h008};
    vecs[2] = '{4'd5, 1'b1, 1'b1, 0, 4'd5, 1'b1, 4'd0, 1'b0, STALL, STALL};
    vecs[3] = '{4'd5, 1'b1, 1'b1, 1, 4'd5, 1'b1, 4'd0, 1'b0, STALL, 10'h008};
    vecs[4] = '{4'd0, 1'b1, 1'b0, 0, 4'd0, 1'b1, 4'd0, 1'b1, QUIET, QUIET};
    vecs[5] = '{4'd3, 1'b1, 1'b0, 0, 4'd0, 1'b0, 4'd3, 1'b1, STALL, 10'h001};
    vecs[6] = '{4'd3, 1'b1, 1'b0, 2, 4'd3, 1'b1, 4'd3, 1'b1, QUIET, QUIET};
    vecs[7] = '{4'd3, 1'b0, 1'b0, 0, 4'd3, 1'b1, 4'd0, 1'b0, QUIET, QUIET};
    vecs[8] = '{4'd3, 1'b1, 1'b0, 0, 4'd3, 1'b0, 4'd0, 1'b0, QUIET, QUIET};
    vecs[9] = '{4'd7, 1'b1, 1'b0, 0, 4'd6, 1'b1, 4'd0, 1'b0, QUIET, QUIET};

    for (int i = 0; i < 10; i++) begin
      doReset();
      applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, vecs[i].pRd, vecs[i].pWe, vecs[i].pLoad, 4'd0, 1'b0);
      step();
      for (int g = 0; g < vecs[i].gap; g++) begin
        idle();
        step();
      end
      applyStimulus(1'b1, vecs[i].cRs1, vecs[i].cU1, vecs[i].cRs2, vecs[i].cU2, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("vec%0d", i), int'(dutOut()), int'(FWD ? vecs[i].expFw : vecs[i].expNo));
    end

    runRaw("alu_use",  1'b0, 4'd3, FWD ? 0 : 2, FWD ? 2'd1 : 2'd0);
    runRaw("load_use", 1'b1, 4'd5, FWD ? 1 : 2, FWD ? 2'd2 : 2'd0);
    runRaw("r0_use",   1'b0, 4'd0, 0, 2'd0);

    runMc(4'd3);
    runMc(4'd15);

    // Branch beats a simultaneous RAW hazard; the re-presented consumer sees wb only.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("br_over_raw", int'(dutOut()), int'(FWD ? 10'h0E4 : FLUSH));
    step();
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("after_br", int'(dutOut()), int'(FWD ? 10'h008 : STALL));

    // Branch is ignored while exe is busy.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0);
    step();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("br_while_busy", int'(dutOut()), int'(BUSY));
    step();
    idle();
    checkOutput("busy_last", int'(dutOut()), int'(BUSY));
    step();
    idle();
    checkOutput("busy_over", int'(dutOut()), int'(QUIET));

    // Asynchronous reset in the middle of a 3-cycle op.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd3, 1'b0);
    step();
    idle();
    checkOutput("mc_pre_rst", int'(dutOut()), int'(BUSY));
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_mc", int'(dutOut()), int'(QUIET));
    step();
    rst = 1'b0;
    #2;
    checkOutput("rst_mid_first", int'(dutOut()), int'(QUIET));
    step();
    idle();
    checkOutput("rst_no_resume", int'(dutOut()), int'(QUIET));

    // Randomized run against the model.
    doReset();
    flight = {};
    flight.push_back('0);
    flight.push_back('0);
    mcLeft = 0;
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      mc = (r < 85) ? 4'd0 : (r < 98) ? 4'($urandom_range(1, 4)) : 4'd15;
      applyStimulus($urandom_range(0, 9) != 0,
                    4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 3) == 0, mc, $urandom_range(0, 9) == 0);
      exp = modelOut();
      checkOutput($sformatf("rand%0d", i), int'(dutOut()), int'(exp));
      modelAdvance(exp[7]);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
